// File: rtl/enigma_core_sequencer.sv
// ---------------------------------------------------------------------------
// enigma_core_sequencer
//   Drives one nucleu_enigma core on behalf of the UART command FSM.
//   - Holds the plugboard table, which is applied on the way in and on the way out.
//   - Latches rotor start positions and pulses core_load_config.
//   - Stretches core strobes for STRETCH cycles so the slower core clock sees them.
//   - Waits for a rising edge on core_valid_out, or gives up after TIMEOUT_CYCLES.
//   - Returns the plugboarded result with a valid/ready handshake.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   cfg_load, cfg_pos1..3    load rotor start positions (accepted in IDLE only)
//   pb_wr_en, pb_wr_a/b      swap-write one plugboard pair
//   pb_clear                 restore the identity plugboard
//   req_valid/ready/char     character request
//   rsp_valid/ready/char/err result; char 31 with err=1 on timeout or bad index
//   busy                     sequencer not in IDLE
//   core_*                   connections to the enigma core
// ---------------------------------------------------------------------------
module enigma_core_sequencer #(
    parameter int STRETCH        = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_load,
    input  logic [4:0] cfg_pos1,
    input  logic [4:0] cfg_pos2,
    input  logic [4:0] cfg_pos3,
    input  logic       pb_wr_en,
    input  logic [4:0] pb_wr_a,
    input  logic [4:0] pb_wr_b,
    input  logic       pb_clear,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_char,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [4:0] rsp_char,
    output logic       rsp_err,
    output logic       busy,
    output logic       core_valid_in,
    output logic [4:0] core_char_in,
    output logic       core_load_config,
    output logic [4:0] core_pos1,
    output logic [4:0] core_pos2,
    output logic [4:0] core_pos3,
    input  logic [4:0] core_char_out,
    input  logic       core_valid_out
);

    localparam int SW = $clog2(STRETCH + 1);
    localparam logic [4:0] ERR_CHAR = 5'd31;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] stretch_cnt_reg, stretch_cnt_next;
    logic [7:0]    to_cnt_reg, to_cnt_next;
    logic          vo_prev_reg;
    logic          core_valid_in_reg, core_valid_in_next;
    logic          core_load_config_reg, core_load_config_next;
    logic [4:0]    core_char_in_reg, core_char_in_next;
    logic [4:0]    pos1_reg, pos1_next, pos2_reg, pos2_next, pos3_reg, pos3_next;
    logic [4:0]    rsp_char_reg, rsp_char_next;
    logic          rsp_err_reg, rsp_err_next;

    logic [4:0]    pb_map [26];
    logic          in_idle, pb_clear_go, pb_wr_go, req_fire, vo_edge;
    logic [4:0]    pb_req, pb_res;

    assign in_idle     = (state_reg == S_IDLE);
    // Lower-priority operations only act when nothing above them is present this cycle.
    assign pb_clear_go = in_idle && !cfg_load && pb_clear;
    assign pb_wr_go    = in_idle && !cfg_load && !pb_clear && pb_wr_en
                         && (pb_wr_a <= 5'd25) && (pb_wr_b <= 5'd25);
    // Gated by rst so every output reads 0 while reset is held.
    assign req_ready   = !rst && in_idle && !cfg_load && !pb_clear && !pb_wr_en;
    assign req_fire    = req_valid && req_ready;
    assign vo_edge     = core_valid_out && !vo_prev_reg;

    assign pb_req = (req_char <= 5'd25) ? pb_map[req_char] : ERR_CHAR;
    assign pb_res = (core_char_out <= 5'd25) ? pb_map[core_char_out] : ERR_CHAR;

    // Plugboard: one register per letter. Writing a==b leaves the old partner of a untouched.
    for (genvar gi = 0; gi < 26; gi++) begin : g_pb
        logic [4:0] entry_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_reg <= 5'(gi);
            end else if (pb_clear_go) begin
                entry_reg <= 5'(gi);
            end else if (pb_wr_go && (pb_wr_a == 5'(gi))) begin
                entry_reg <= pb_wr_b;
            end else if (pb_wr_go && (pb_wr_b == 5'(gi))) begin
                entry_reg <= pb_wr_a;
            end
        end
        assign pb_map[gi] = entry_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg            <= S_IDLE;
            stretch_cnt_reg      <= '0;
            to_cnt_reg           <= '0;
            vo_prev_reg          <= 1'b0;
            core_valid_in_reg    <= 1'b0;
            core_load_config_reg <= 1'b0;
            core_char_in_reg     <= '0;
            pos1_reg             <= '0;
            pos2_reg             <= '0;
            pos3_reg             <= '0;
            rsp_char_reg         <= '0;
            rsp_err_reg          <= 1'b0;
        end else begin
            state_reg            <= state_next;
            stretch_cnt_reg      <= stretch_cnt_next;
            to_cnt_reg           <= to_cnt_next;
            vo_prev_reg          <= core_valid_out;
            core_valid_in_reg    <= core_valid_in_next;
            core_load_config_reg <= core_load_config_next;
            core_char_in_reg     <= core_char_in_next;
            pos1_reg             <= pos1_next;
            pos2_reg             <= pos2_next;
            pos3_reg             <= pos3_next;
            rsp_char_reg         <= rsp_char_next;
            rsp_err_reg          <= rsp_err_next;
        end
    end

    always_comb begin
        state_next            = state_reg;
        stretch_cnt_next      = stretch_cnt_reg;
        to_cnt_next           = to_cnt_reg;
        core_valid_in_next    = core_valid_in_reg;
        core_load_config_next = core_load_config_reg;
        core_char_in_next     = core_char_in_reg;
        pos1_next             = pos1_reg;
        pos2_next             = pos2_reg;
        pos3_next             = pos3_reg;
        rsp_char_next         = rsp_char_reg;
        rsp_err_next          = rsp_err_reg;
        case (state_reg)
            S_IDLE: begin
                if (cfg_load) begin
                    pos1_next             = cfg_pos1;
                    pos2_next             = cfg_pos2;
                    pos3_next             = cfg_pos3;
                    core_load_config_next = 1'b1;
                    stretch_cnt_next      = '0;
                    state_next            = S_LOAD;
                end else if (req_fire) begin
                    if (req_char > 5'd25) begin
                        // Bad index: answer straight away without touching the core.
                        rsp_char_next = ERR_CHAR;
                        rsp_err_next  = 1'b1;
                        state_next    = S_RESP;
                    end else begin
                        core_char_in_next  = pb_req;
                        core_valid_in_next = 1'b1;
                        stretch_cnt_next   = '0;
                        state_next         = S_ISSUE;
                    end
                end
            end
            S_LOAD: begin
                if (stretch_cnt_reg == SW'(STRETCH - 1)) begin
                    core_load_config_next = 1'b0;
                    state_next            = S_IDLE;
                end else begin
                    stretch_cnt_next = stretch_cnt_reg + 1'b1;
                end
            end
            S_ISSUE: begin
                if (stretch_cnt_reg == SW'(STRETCH - 1)) begin
                    core_valid_in_next = 1'b0;
                    to_cnt_next        = '0;
                    state_next         = S_WAIT;
                end else begin
                    stretch_cnt_next = stretch_cnt_reg + 1'b1;
                end
            end
            S_WAIT: begin
                if (vo_edge) begin
                    rsp_char_next = pb_res;
                    rsp_err_next  = (core_char_out > 5'd25);
                    state_next    = S_RESP;
                end else if (to_cnt_reg == 8'(TIMEOUT_CYCLES - 1)) begin
                    rsp_char_next = ERR_CHAR;
                    rsp_err_next  = 1'b1;
                    state_next    = S_RESP;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_char_next = '0;
                    rsp_err_next  = 1'b0;
                    state_next    = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign rsp_valid        = (state_reg == S_RESP);
    assign busy             = !in_idle;
    assign rsp_char         = rsp_char_reg;
    assign rsp_err          = rsp_err_reg;
    assign core_valid_in    = core_valid_in_reg;
    assign core_char_in     = core_char_in_reg;
    assign core_load_config = core_load_config_reg;
    assign core_pos1        = pos1_reg;
    assign core_pos2        = pos2_reg;
    assign core_pos3        = pos3_reg;

endmodule
